// File: rtl/card_pkg.sv
// Shared constants, state encoding and card-map slicing for the card-match game.
package card_pkg;

  localparam int NUM_CARDS = 16;
  localparam int SYM_W     = 3;
  localparam int NUM_PAIRS = 8;
  localparam int MAP_W     = NUM_CARDS * SYM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRST,
    S_SECOND,
    S_COMPARE,
    S_SHOW,
    S_WIN
  } state_t;

  // Symbol of card idx lives at map[3*idx +: 3] (ascending-range map).
  function automatic logic [SYM_W-1:0] card_sym(input logic [0:MAP_W-1] map,
                                                input logic [3:0] idx);
    return map[int'(idx)*SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (en_i && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign expired_o = (value_q == '0);

endmodule

// File: rtl/card_match_ctrl.sv
// Card-flip round controller: loads the shuffled map, runs two-card selections,
// keeps matches face-up, re-hides misses after a hold time and flags the win.
module card_match_ctrl
  import card_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int MOVE_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_game,
  output logic              shuffle_start,
  input  logic [0:47]       map_in,
  input  logic              map_valid,
  input  logic [3:0]        sel_idx,
  input  logic              sel_valid,
  output logic [15:0]       face_up,
  output logic [15:0]       matched,
  output logic [0:47]       sym_out,
  output logic [3:0]        pair_count,
  output logic [MOVE_W-1:0] moves,
  output logic              match_pulse,
  output logic              miss_pulse,
  output logic              busy,
  output logic              game_over
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [NUM_CARDS-1:0]   face_q, face_d;
  logic [NUM_CARDS-1:0]   matched_q, matched_d;
  logic [0:MAP_W-1]       sym_q, sym_d;
  logic [3:0]             pairs_q, pairs_d;
  logic [MOVE_W-1:0]      moves_q, moves_d;
  logic [3:0]             idx_a_q, idx_a_d;
  logic [3:0]             idx_b_q, idx_b_d;
  logic                   shuf_q, shuf_d;

  logic tmr_load, tmr_en, tmr_expired;
  logic sel_hidden, sym_eq;

  hold_timer #(.W(TW)) u_hold_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (tmr_load),
    .load_val_i (HOLD_LOAD),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  assign sel_hidden = !face_q[sel_idx] && !matched_q[sel_idx];
  assign sym_eq     = (card_sym(sym_q, idx_a_q) == card_sym(sym_q, idx_b_q));

  always_comb begin
    state_d     = state_q;
    face_d      = face_q;
    matched_d   = matched_q;
    sym_d       = sym_q;
    pairs_d     = pairs_q;
    moves_d     = moves_q;
    idx_a_d     = idx_a_q;
    idx_b_d     = idx_b_q;
    shuf_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    match_pulse = 1'b0;
    miss_pulse  = 1'b0;

    // new_game overrides everything else, including a same-cycle map_valid.
    if (new_game) begin
      shuf_d    = 1'b1;
      face_d    = '0;
      matched_d = '0;
      pairs_d   = '0;
      moves_d   = '0;
      state_d   = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (map_valid) begin
            sym_d   = map_in;
            state_d = S_FIRST;
          end
        end
        S_FIRST: begin
          if (sel_valid && sel_hidden) begin
            face_d[sel_idx] = 1'b1;
            idx_a_d         = sel_idx;
            state_d         = S_SECOND;
          end
        end
        S_SECOND: begin
          if (sel_valid && sel_hidden && (sel_idx != idx_a_q)) begin
            face_d[sel_idx] = 1'b1;
            idx_b_d         = sel_idx;
            state_d         = S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (moves_q != {MOVE_W{1'b1}}) moves_d = moves_q + 1'b1;
          if (sym_eq) begin
            match_pulse = 1'b1;
            matched_d   = matched_q | (16'd1 << idx_a_q) | (16'd1 << idx_b_q);
            pairs_d     = pairs_q + 4'd1;
            state_d     = (pairs_q + 4'd1 == 4'(NUM_PAIRS)) ? S_WIN : S_FIRST;
          end else begin
            miss_pulse = 1'b1;
            tmr_load   = 1'b1;
            state_d    = S_SHOW;
          end
        end
        S_SHOW: begin
          if (tmr_expired) begin
            face_d[idx_a_q] = 1'b0;
            face_d[idx_b_q] = 1'b0;
            state_d         = S_FIRST;
          end else begin
            tmr_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      face_q    <= '0;
      matched_q <= '0;
      sym_q     <= '0;
      pairs_q   <= '0;
      moves_q   <= '0;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      shuf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      face_q    <= face_d;
      matched_q <= matched_d;
      sym_q     <= sym_d;
      pairs_q   <= pairs_d;
      moves_q   <= moves_d;
      idx_a_q   <= idx_a_d;
      idx_b_q   <= idx_b_d;
      shuf_q    <= shuf_d;
    end
  end

  assign shuffle_start = shuf_q;
  assign face_up       = face_q;
  assign matched       = matched_q;
  assign sym_out       = sym_q;
  assign pair_count    = pairs_q;
  assign moves         = moves_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_COMPARE) || (state_q == S_SHOW);
  assign game_over     = (state_q == S_WIN);

endmodule

// File: tb/tb_card_match_ctrl.sv
// Bench for card_match_ctrl with a short hold time and a transaction-level game model.
module tb_card_match_ctrl;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        shuffle_start;
  logic [0:47] map_in;
  logic        map_valid;
  logic [3:0]  sel_idx;
  logic        sel_valid;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [0:47] sym_out;
  logic [3:0]  pair_count;
  logic [7:0]  moves;
  logic        match_pulse;
  logic        miss_pulse;
  logic        busy;
  logic        game_over;

  int checks   = 0;
  int failures = 0;

  int          m_sym[16];
  logic [15:0] m_face;
  logic [15:0] m_match;
  int          m_pairs;
  int          m_moves;
  logic [0:47] ref_map;

  always #5 clk = ~clk;

  card_match_ctrl #(.HOLD_CYCLES(HOLD), .MOVE_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .new_game      (new_game),
    .shuffle_start (shuffle_start),
    .map_in        (map_in),
    .map_valid     (map_valid),
    .sel_idx       (sel_idx),
    .sel_valid     (sel_valid),
    .face_up       (face_up),
    .matched       (matched),
    .sym_out       (sym_out),
    .pair_count    (pair_count),
    .moves         (moves),
    .match_pulse   (match_pulse),
    .miss_pulse    (miss_pulse),
    .busy          (busy),
    .game_over     (game_over)
  );

  function automatic logic [0:47] build_map();
    logic [0:47] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[3*i +: 3] = 3'(m_sym[i]);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_face = '0; m_match = '0; m_pairs = 0; m_moves = 0;
  endtask

  task automatic do_load(input logic [0:47] m);
    map_in = m; map_valid = 1'b1;
    tick();
    map_valid = 1'b0;
  endtask

  task automatic do_sel(input int idx);
    sel_idx = 4'(idx); sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [96:0] all_out;
    int shuf_cnt;
    int busy_cnt;
    do_new_game();
    do_load(ref_map);
    do_sel(0);
    do_sel(2);
    tick();
    checks++;
    if (miss_pulse !== 1'b0 || busy !== 1'b1 || face_up !== 16'h0005) begin
      failures++;
      $display("FAIL reset_pre_show: busy=%b face_up=%h required busy=1 face_up=0005", busy, face_up);
    end
    #2 reset = 1'b1;
    #1;
    all_out = {shuffle_start, face_up, matched, sym_out, pair_count, moves,
               match_pulse, miss_pulse, busy, game_over};
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    tick();
    reset = 1'b0;
    shuf_cnt = 0; busy_cnt = 0;
    map_in = ~ref_map;
    for (int c = 0; c < 6; c++) begin
      map_valid = (c == 1);
      sel_idx   = 4'(c); sel_valid = 1'b1;
      tick();
      if (shuffle_start) shuf_cnt++;
      if (busy) busy_cnt++;
    end
    sel_valid = 1'b0; map_valid = 1'b0;
    checks++;
    if (shuf_cnt !== 0 || busy_cnt !== 0) begin
      failures++;
      $display("FAIL reset_idle: shuffle=%0d busy=%0d required 0 0", shuf_cnt, busy_cnt);
    end
    checks++;
    if (face_up !== 16'h0 || sym_out !== '0) begin
      failures++;
      $display("FAIL reset_idle_ignore: face_up=%h sym_out=%h required 0 0", face_up, sym_out);
    end
  endtask

  task automatic test_match();
    int shuf_cnt;
    do_new_game();
    shuf_cnt = shuffle_start ? 1 : 0;
    checks++;
    if (busy !== 1'b1 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL match_load_state: busy=%b game_over=%b required 1 0", busy, game_over);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (shuffle_start) shuf_cnt++;
    end
    checks++;
    if (shuf_cnt !== 1) begin
      failures++;
      $display("FAIL match_shuffle_once: pulses=%0d required 1", shuf_cnt);
    end
    do_load(ref_map);
    checks++;
    if (sym_out !== ref_map || busy !== 1'b0) begin
      failures++;
      $display("FAIL match_map_load: sym_out=%h busy=%b required %h 0", sym_out, busy, ref_map);
    end
    do_sel(0);
    checks++;
    if (face_up !== 16'h0001) begin
      failures++;
      $display("FAIL match_first_face: got %h required 0001", face_up);
    end
    do_sel(1);
    checks++;
    if (match_pulse !== 1'b1 || miss_pulse !== 1'b0) begin
      failures++;
      $display("FAIL match_pulse: match=%b miss=%b required 1 0", match_pulse, miss_pulse);
    end
    tick();
    checks++;
    if (matched !== 16'h0003 || pair_count !== 4'd1 || moves !== 8'd1 || face_up !== 16'h0003) begin
      failures++;
      $display("FAIL match_result: matched=%h pairs=%0d moves=%0d face=%h required 0003 1 1 0003",
               matched, pair_count, moves, face_up);
    end
  endtask

  task automatic test_mismatch();
    int n;
    do_sel(2);
    do_sel(4);
    checks++;
    if (miss_pulse !== 1'b1 || match_pulse !== 1'b0) begin
      failures++;
      $display("FAIL miss_pulse: miss=%b match=%b required 1 0", miss_pulse, match_pulse);
    end
    n = 0;
    sel_idx = 4'd6; sel_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if ((face_up & ~matched) !== 16'h0014) break;
      n++;
      tick();
    end
    sel_valid = 1'b0;
    checks++;
    if (n !== HOLD + 1) begin
      failures++;
      $display("FAIL miss_visible_cycles: got %0d required %0d", n, HOLD + 1);
    end
    checks++;
    if (face_up !== 16'h0003 || moves !== 8'd2 || pair_count !== 4'd1) begin
      failures++;
      $display("FAIL miss_after_hide: face=%h moves=%0d pairs=%0d required 0003 2 1",
               face_up, moves, pair_count);
    end
  endtask

  task automatic test_reselect();
    do_sel(3);
    do_sel(3);
    do_sel(0);
    checks++;
    if (face_up !== 16'h000B || busy !== 1'b0 || match_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reselect_ignored: face=%h busy=%b required 000b 0", face_up, busy);
    end
    do_sel(2);
    checks++;
    if (match_pulse !== 1'b1) begin
      failures++;
      $display("FAIL reselect_match: match_pulse=%b required 1", match_pulse);
    end
    tick();
    checks++;
    if (matched !== 16'h000F || pair_count !== 4'd2 || moves !== 8'd3) begin
      failures++;
      $display("FAIL reselect_result: matched=%h pairs=%0d moves=%0d required 000f 2 3",
               matched, pair_count, moves);
    end
  endtask

  task automatic test_full_game();
    int hits;
    do_new_game();
    checks++;
    if (face_up !== 16'h0 || matched !== 16'h0 || moves !== 8'd0 || pair_count !== 4'd0) begin
      failures++;
      $display("FAIL full_clear: face=%h matched=%h moves=%0d pairs=%0d required all 0",
               face_up, matched, moves, pair_count);
    end
    do_load(ref_map);
    hits = 0;
    for (int p = 0; p < 8; p++) begin
      do_sel(2*p);
      do_sel(2*p + 1);
      if (match_pulse === 1'b1) hits++;
      tick();
    end
    checks++;
    if (hits !== 8) begin
      failures++;
      $display("FAIL full_match_pulses: got %0d required 8", hits);
    end
    checks++;
    if (pair_count !== 4'd8 || game_over !== 1'b1 || moves !== 8'd8 ||
        matched !== 16'hFFFF || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_win: pairs=%0d over=%b moves=%0d matched=%h busy=%b required 8 1 8 ffff 0",
               pair_count, game_over, moves, matched, busy);
    end
    do_sel(5);
    do_sel(9);
    tick();
    checks++;
    if (game_over !== 1'b1 || moves !== 8'd8 || face_up !== 16'hFFFF || pair_count !== 4'd8) begin
      failures++;
      $display("FAIL full_win_hold: over=%b moves=%0d face=%h required 1 8 ffff", game_over, moves, face_up);
    end
  endtask

  task automatic test_new_game_collision();
    logic [0:47] alt;
    for (int i = 0; i < 16; i++) m_sym[i] = 7 - (i >> 1);
    alt = build_map();
    for (int i = 0; i < 16; i++) m_sym[i] = i >> 1;
    do_new_game();
    do_load(ref_map);
    do_sel(5);
    new_game = 1'b1; map_valid = 1'b1; map_in = alt;
    tick();
    new_game = 1'b0; map_valid = 1'b0;
    checks++;
    if (face_up !== 16'h0 || shuffle_start !== 1'b1 || busy !== 1'b1 || sym_out !== ref_map) begin
      failures++;
      $display("FAIL collide_state: face=%h shuf=%b busy=%b sym=%h required 0 1 1 %h",
               face_up, shuffle_start, busy, sym_out, ref_map);
    end
    do_sel(4);
    checks++;
    if (face_up !== 16'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL collide_load_wait: face=%h busy=%b required 0 1", face_up, busy);
    end
    do_load(alt);
    do_sel(0);
    checks++;
    if (sym_out !== alt || busy !== 1'b0 || face_up !== 16'h0001) begin
      failures++;
      $display("FAIL collide_reload: sym=%h busy=%b face=%h required %h 0 0001", sym_out, busy, face_up, alt);
    end
  endtask

  task automatic test_random_game();
    int idx, a, phase, partner, tmp, j, acc;
    int hid[$];
    for (int i = 0; i < 16; i++) m_sym[i] = i >> 1;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = m_sym[i]; m_sym[i] = m_sym[j]; m_sym[j] = tmp;
    end
    do_new_game();
    do_load(build_map());
    phase = 0; a = 0;
    for (int step = 0; step < 300 && m_pairs < 8; step++) begin
      hid.delete();
      for (int i = 0; i < 16; i++) if (!m_face[i]) hid.push_back(i);
      if ($urandom_range(0, 4) == 0) idx = $urandom_range(0, 15);
      else idx = hid[$urandom_range(0, hid.size() - 1)];
      if (phase == 1 && $urandom_range(0, 1) == 1) begin
        partner = -1;
        for (int i = 0; i < 16; i++)
          if (i != a && m_sym[i] == m_sym[a] && !m_face[i]) partner = i;
        if (partner >= 0) idx = partner;
      end
      acc = m_face[idx] ? 0 : 1;
      do_sel(idx);
      if (acc == 1) m_face[idx] = 1'b1;
      checks++;
      if (face_up !== m_face) begin
        failures++;
        $display("FAIL rand_face step %0d: got %h required %h", step, face_up, m_face);
      end
      if (acc == 1 && phase == 0) begin
        a = idx; phase = 1;
      end else if (acc == 1) begin
        phase = 0;
        if (m_moves < 255) m_moves++;
        if (m_sym[a] == m_sym[idx]) begin
          checks++;
          if (match_pulse !== 1'b1 || miss_pulse !== 1'b0) begin
            failures++;
            $display("FAIL rand_match step %0d: match=%b miss=%b required 1 0", step, match_pulse, miss_pulse);
          end
          m_match[a] = 1'b1; m_match[idx] = 1'b1; m_pairs++;
          tick();
        end else begin
          checks++;
          if (miss_pulse !== 1'b1 || match_pulse !== 1'b0) begin
            failures++;
            $display("FAIL rand_miss step %0d: miss=%b match=%b required 1 0", step, miss_pulse, match_pulse);
          end
          for (int c = 0; c < HOLD + 1; c++) tick();
          m_face[a] = 1'b0; m_face[idx] = 1'b0;
        end
        checks++;
        if (face_up !== m_face || matched !== m_match || pair_count !== 4'(m_pairs) ||
            moves !== 8'(m_moves)) begin
          failures++;
          $display("FAIL rand_after step %0d: face=%h matched=%h pairs=%0d moves=%0d required %h %h %0d %0d",
                   step, face_up, matched, pair_count, moves, m_face, m_match, m_pairs, m_moves);
        end
      end
    end
    checks++;
    if (game_over !== (m_pairs == 8)) begin
      failures++;
      $display("FAIL rand_game_over: got %b required %b", game_over, (m_pairs == 8));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; new_game = 1'b0; map_in = '0; map_valid = 1'b0;
    sel_idx = '0; sel_valid = 1'b0;
    m_face = '0; m_match = '0; m_pairs = 0; m_moves = 0;
    for (int i = 0; i < 16; i++) m_sym[i] = i >> 1;
    ref_map = build_map();
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_match();
    test_mismatch();
    test_reselect();
    test_full_game();
    test_new_game_collision();
    test_random_game();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
